// File: rtl/ysyx_22040895_idu_stage.sv
// ysyx_22040895_idu_stage -- instruction decode stage with a two-entry skid buffer.
//
// Decodes the incoming RV instruction combinationally and captures the decoded
// bundle into a main/skid register pair so that in_ready can be registered
// (it never depends combinationally on out_ready).
//
// Optional feature: define YSYX_22040895_IDU_ILLEGAL_EN to enable illegal
// instruction detection on illegal_o. Without it illegal_o is tied low.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake (in_ready registered)
//   inst_i, pc_i             instruction word and its address
//   flush                    drop buffered and same-cycle incoming instructions
//   out_valid/out_ready      downstream handshake
//   pc_o .. rdaddr_o         decoded fields of the presented bundle
//   imm_o, fmt_o             sign-extended immediate, format (R0 I1 S2 B3 U4 J5)
//   rs1_en, rs2_en, rd_we    operand-read and writeback enables
//   illegal_o                illegal-instruction flag
module ysyx_22040895_idu_stage #(
  parameter int XLEN    = 64,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        inst_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    pc_o,
  output logic [6:0]         opcode_o,
  output logic [2:0]         func3_o,
  output logic [6:0]         func7_o,
  output logic [RADDR_W-1:0] rs1addr_o,
  output logic [RADDR_W-1:0] rs2addr_o,
  output logic [RADDR_W-1:0] rdaddr_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [2:0]         fmt_o,
  output logic               rs1_en,
  output logic               rs2_en,
  output logic               rd_we,
  output logic               illegal_o
);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic [6:0]         func7;
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic [RADDR_W-1:0] rd;
    logic [XLEN-1:0]    imm;
    logic [2:0]         fmt;
    logic               rs1_en;
    logic               rs2_en;
    logic               rd_we;
    logic               illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  bundle_t dec, main_q, skid_q;
  state_t  state;
  logic    known;
  logic    accept, drain;

  // ---------------- combinational decode ----------------
  always_comb begin
    dec        = '0;
    known      = 1'b1;
    dec.pc     = pc_i;
    dec.opcode = inst_i[6:0];
    dec.func3  = inst_i[14:12];
    dec.func7  = inst_i[31:25];
    dec.rs1    = RADDR_W'(inst_i[19:15]);
    dec.rs2    = RADDR_W'(inst_i[24:20]);
    dec.rd     = RADDR_W'(inst_i[11:7]);
    unique case (inst_i[6:0])
      7'b0110011, 7'b0111011:                         dec.fmt = FMT_R;
      7'b0010011, 7'b0011011, 7'b0000011,
      7'b1100111, 7'b1110011:                         dec.fmt = FMT_I;
      7'b0100011:                                     dec.fmt = FMT_S;
      7'b1100011:                                     dec.fmt = FMT_B;
      7'b0110111, 7'b0010111:                         dec.fmt = FMT_U;
      7'b1101111:                                     dec.fmt = FMT_J;
      default: begin
        dec.fmt = FMT_R;
        known   = 1'b0;
      end
    endcase
    if (inst_i[1:0] != 2'b11) known = 1'b0;

    // Signed casts sign-extend to XLEN from the top bit of each field.
    case (dec.fmt)
      FMT_I: dec.imm = XLEN'($signed(inst_i[31:20]));
      FMT_S: dec.imm = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
      FMT_B: dec.imm = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25],
                                      inst_i[11:8], 1'b0}));
      FMT_U: dec.imm = XLEN'($signed({inst_i[31:12], 12'b0}));
      FMT_J: dec.imm = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20],
                                      inst_i[30:21], 1'b0}));
      default: dec.imm = '0;
    endcase

    // Unknown opcodes fall through as an inert R-type bundle.
    if (known) begin
      dec.rs1_en = (dec.fmt == FMT_R) || (dec.fmt == FMT_I) ||
                   (dec.fmt == FMT_S) || (dec.fmt == FMT_B);
      dec.rs2_en = (dec.fmt == FMT_R) || (dec.fmt == FMT_S) || (dec.fmt == FMT_B);
      dec.rd_we  = ((dec.fmt == FMT_R) || (dec.fmt == FMT_I) ||
                    (dec.fmt == FMT_U) || (dec.fmt == FMT_J)) && (dec.rd != '0);
    end
`ifdef YSYX_22040895_IDU_ILLEGAL_EN
    dec.illegal = ~known;
`else
    dec.illegal = 1'b0;
`endif
  end

  // ---------------- two-entry buffer ----------------
  assign accept = in_valid & in_ready & ~flush;
  assign drain  = out_valid & out_ready;

  // Emptied entries are cleared so the outputs read 0 whenever out_valid is 0.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          main_q    <= dec;
          state     <= ONE;
          out_valid <= 1'b1;
        end
        ONE: begin
          if (accept && drain) begin
            main_q <= dec;
          end else if (accept) begin
            skid_q   <= dec;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (drain) begin
            main_q    <= '0;
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: if (drain) begin
          main_q   <= skid_q;
          skid_q   <= '0;
          state    <= ONE;
          in_ready <= 1'b1;
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc_o      = main_q.pc;
  assign opcode_o  = main_q.opcode;
  assign func3_o   = main_q.func3;
  assign func7_o   = main_q.func7;
  assign rs1addr_o = main_q.rs1;
  assign rs2addr_o = main_q.rs2;
  assign rdaddr_o  = main_q.rd;
  assign imm_o     = main_q.imm;
  assign fmt_o     = main_q.fmt;
  assign rs1_en    = main_q.rs1_en;
  assign rs2_en    = main_q.rs2_en;
  assign rd_we     = main_q.rd_we;
  assign illegal_o = main_q.illegal;

endmodule

// File: doc/ysyx_22040895_idu_stage.md
YSYX_22040895_IDU_STAGE -- requirements
Module: ysyx_22040895_idu_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, data/PC width; legal values 32 or 64.
REQ-002 SHALL have parameter RADDR_W, default 5, register address width.
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high (asserted = 1'b1).
REQ-005 SHALL have port in_valid  in  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  out  1  stage can accept; registered, not combinational from out_ready.
REQ-007 SHALL have port inst_i  in  32  instruction word.
REQ-008 SHALL have port pc_i  in  XLEN  instruction address.
REQ-009 SHALL have port flush  in  1  discard all buffered and incoming instructions.
REQ-010 SHALL have port out_valid  out  1  decoded bundle valid.
REQ-011 SHALL have port out_ready  in  1  downstream accepts bundle.
REQ-012 SHALL have ports pc_o XLEN, opcode_o 7, func3_o 3, func7_o 7, rs1addr_o/rs2addr_o/rdaddr_o RADDR_W, all out: decoded fields.
REQ-013 SHALL have port imm_o  out  XLEN  fully assembled, sign-extended immediate.
REQ-014 SHALL have port fmt_o  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5.
REQ-015 SHALL have ports rs1_en, rs2_en, rd_we  out  1 each  operand-read and writeback enables.
REQ-016 SHALL have port illegal_o  out  1  illegal-instruction flag.

Function
REQ-017 SHALL transfer in on in_valid&in_ready and out on out_valid&out_ready.
REQ-018 SHALL decode combinationally from inst_i and capture the bundle; latency 1 cycle (accepted at edge N, out_valid at N+1 if buffer was empty).
REQ-019 SHALL buffer 2 entries (main + skid); states EMPTY, ONE, TWO.
REQ-020 EMPTY: accept -> ONE. ONE: accept without drain -> TWO; drain without accept -> EMPTY; both -> ONE. TWO: drain -> ONE; no accept possible.
REQ-021 SHALL drive in_ready = 1 in EMPTY/ONE, 0 in TWO; out_valid = 1 in ONE/TWO.
REQ-022 SHALL preserve order: skid entry presented only after main entry drains; no bundle duplicated or dropped.
REQ-023 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-024 Immediates: I = sext(inst[31:20]); S = sext({inst[31:25],inst[11:7]}); B = sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U = sext({inst[31:12],12'b0}) from bit 31; J = sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); R -> 0.
REQ-025 Format by opcode: 0110011/0111011 R; 0010011/0011011/0000011/1100111/1110011 I; 0100011 S; 1100011 B; 0110111/0010111 U; 1101111 J.
REQ-026 rs1_en = 1 for R,I,S,B; rs2_en = 1 for R,S,B; rd_we = 1 for R,I,U,J and rdaddr != 0; otherwise 0.
REQ-027 flush SHALL empty buffer at next edge (state EMPTY, out_valid 0); an input handshaking in the same cycle as flush SHALL be discarded (flush wins).
REQ-028 Output fields SHALL be 0 whenever out_valid = 0.

Reset
REQ-029 rst=1 at edge SHALL force EMPTY; all outputs 0 next cycle except in_ready = 1.
REQ-030 rst mid-transfer SHALL drop buffered entries; rst SHALL dominate flush and in_valid.

Configuration
REQ-031 Macro YSYX_22040895_IDU_ILLEGAL_EN SHALL gate illegal detection.
REQ-032 Defined: illegal_o = 1 when inst[1:0] != 2'b11 or opcode not in REQ-025 list; then fmt_o = R, rs1_en/rs2_en/rd_we = 0, imm_o = 0; bundle still passed in order.
REQ-033 Undefined: illegal_o tied 0; unknown opcodes decode as R with enables 0.

Verification
REQ-034 inst 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle imm_o=0xFFFF_FFFF_FFFF_FFFF, fmt_o=1, rdaddr_o=1, rd_we=1.
REQ-035 inst 0xFE000EE3 (beq x0,x0,-4) -> imm_o=0xFFFF_FFFF_FFFF_FFFC, fmt_o=3, rd_we=0, rs2_en=1.
REQ-036 inst 0x001000EF (jal x1,+2048) -> imm_o=0x800, fmt_o=5; inst 0x800002B7 (lui x5) -> imm_o=0xFFFF_FFFF_8000_0000.
REQ-037 out_ready=0, 3 back-to-back valid inputs pc 0x0/0x4/0x8 -> 2 accepted, in_ready=0 in TWO; raise out_ready -> pc_o 0x0 then 0x4, no loss.
REQ-038 TWO state, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed input never appears.
REQ-039 With macro, inst 0x00000000 -> illegal_o=1, rd_we=0; without macro -> illegal_o=0.
